// File: rtl/sr_reg_bank.sv
// sr_reg_bank: bank of filtered synchronous S-R channels with conflict statistics
module sr_reg_bank #(
   parameter int               WIDTH         = 8,
   parameter int               CONFLICT_MODE = 0,
   parameter int               FILTER        = 2,
   parameter int               CNT_W         = 8,
   parameter logic [WIDTH-1:0] RESET_Q       = {WIDTH{1'b0}}
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             Clr,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic [WIDTH-1:0] Chg,
   output logic             ConflictFlag,
   output logic [CNT_W-1:0] ConflictCnt
);
   localparam logic [3:0] FMAX = 4'(FILTER);
   logic [WIDTH-1:0][3:0] sc_q, sc_d, rc_q, rc_d;
   logic [WIDTH-1:0]      q_q, q_d, chg_q, se, re;
   logic                  flag_q, flag_d, hit;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   // Per-channel qualification counters and next-state resolution; se/re use the pre-edge count
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         sc_d[i] = S[i] ? ((sc_q[i] == FMAX) ? FMAX : sc_q[i] + 4'd1) : 4'd0;
         rc_d[i] = R[i] ? ((rc_q[i] == FMAX) ? FMAX : rc_q[i] + 4'd1) : 4'd0;
         se[i]   = S[i] & (sc_q[i] == FMAX);
         re[i]   = R[i] & (rc_q[i] == FMAX);
         q_d[i]  = (se[i] & re[i]) ? ((CONFLICT_MODE == 1) ? 1'b1 :
                                      (CONFLICT_MODE == 2) ? 1'b0 :
                                      (CONFLICT_MODE == 3) ? ~q_q[i] : q_q[i]) :
                   se[i] ? 1'b1 : re[i] ? 1'b0 : q_q[i];
      end
   end
   assign hit    = |(se & re);
   assign cnt_d  = Clr ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   assign flag_d = Clr ? 1'b0 : flag_q | hit;
   // State, change pulses and conflict statistics; reset discards any partial qualification
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sc_q   <= '0;
         rc_q   <= '0;
         q_q    <= RESET_Q;
         chg_q  <= '0;
         flag_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sc_q   <= sc_d;
         rc_q   <= rc_d;
         q_q    <= q_d;
         chg_q  <= q_d ^ q_q;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end
   assign Q            = q_q;
   assign Qn           = ~q_q;
   assign Chg          = chg_q;
   assign ConflictFlag = flag_q;
   assign ConflictCnt  = cnt_q;
endmodule
